// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch predictor blocks.
package bp_pkg;

  localparam int PC_IDX_LSB = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ctr_max(input int width);
    return (1 << width) - 1;
  endfunction

  // "Weakly not taken": one below the taken threshold.
  function automatic int init_ctr(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_ctr_next.sv
// Next value of an up/down saturating counter; holds when idle.
module sat_ctr_next
  import bp_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] ctr,
  input  logic             up,
  input  logic             dn,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] sum;

  // One extra bit catches both overflow and underflow.
  always_comb begin
    ext = {1'b0, ctr};
    sum = ext;
    nxt = ctr;
    if (up && !dn) begin
      sum = ext + 1'b1;
      nxt = sum[WIDTH] ? WIDTH'(ctr_max(WIDTH)) : sum[WIDTH-1:0];
    end else if (dn && !up) begin
      sum = ext - 1'b1;
      nxt = sum[WIDTH] ? '0 : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table with 1-cycle lookup and update bypass.
// Define BHT_GSHARE_EN for gshare (PC xor global history) indexing.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int LINES     = 128,
  parameter int CTR_WIDTH = 2,
  parameter int INIT_CTR  = init_ctr(CTR_WIDTH),
  localparam int IDX_W    = clog2(LINES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_guess,
  input  logic                is_br_guess,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [IDX_W-1:0]    hist_guess,
  input  logic [PC_WIDTH-1:0] pc_check,
  input  logic                is_br_check,
  input  logic                br_taken_check,
  input  logic [IDX_W-1:0]    hist_check
);

  logic [CTR_WIDTH-1:0] table_q [LINES];
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     uidx;
  logic [IDX_W-1:0]     hist_src;
  logic [CTR_WIDTH-1:0] ctr_cur;
  logic [CTR_WIDTH-1:0] ctr_nxt;
  logic                 up;
  logic                 dn;
  logic                 hit;
  logic                 pred_bit;
  logic                 unused;

  assign unused = ^{pc_guess, pc_check, hist_check};

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (is_br_check) begin
      ghr_q <= IDX_W'({ghr_q, br_taken_check});
    end
  end

  assign hist_src = ghr_q;
  assign idx  = pc_guess[PC_IDX_LSB +: IDX_W] ^ ghr_q;
  assign uidx = pc_check[PC_IDX_LSB +: IDX_W] ^ hist_check;
`else
  assign hist_src = '0;
  assign idx  = pc_guess[PC_IDX_LSB +: IDX_W];
  assign uidx = pc_check[PC_IDX_LSB +: IDX_W];
`endif

  assign up      = is_br_check & br_taken_check;
  assign dn      = is_br_check & ~br_taken_check;
  assign ctr_cur = table_q[uidx];

  sat_ctr_next #(
    .WIDTH(CTR_WIDTH)
  ) u_next (
    .ctr(ctr_cur),
    .up (up),
    .dn (dn),
    .nxt(ctr_nxt)
  );

  // A lookup colliding with an update sees the post-update counter.
  assign hit      = is_br_check && (idx == uidx);
  assign pred_bit = hit ? ctr_nxt[CTR_WIDTH-1]
                        : table_q[idx][CTR_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        table_q[i] <= CTR_WIDTH'(INIT_CTR);
      end
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      hist_guess <= '0;
    end else begin
      if (is_br_check) begin
        table_q[uidx] <= ctr_nxt;
      end
      pred_valid <= is_br_guess;
      pred_taken <= pred_bit;
      hist_guess <= hist_src;
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench: default 2-bit table plus a 3-bit counter instance.
module tb_bht_predictor;
  import bp_pkg::*;

  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc_guess, pc_check;
  logic          is_br_guess, is_br_check, br_taken_check;
  logic [IW-1:0] hist_check;
  logic          pred_valid, pred_taken;
  logic [IW-1:0] hist_guess;

  logic [31:0]   pc_guess3, pc_check3;
  logic          is_br_guess3, is_br_check3, br_taken_check3;
  logic          pred_valid3, pred_taken3;
  logic [IW-1:0] hist_guess3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bht_predictor dut (
    .clk(clk), .rst(rst),
    .pc_guess(pc_guess), .is_br_guess(is_br_guess),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .hist_guess(hist_guess),
    .pc_check(pc_check), .is_br_check(is_br_check),
    .br_taken_check(br_taken_check), .hist_check(hist_check)
  );

  bht_predictor #(.CTR_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst),
    .pc_guess(pc_guess3), .is_br_guess(is_br_guess3),
    .pred_valid(pred_valid3), .pred_taken(pred_taken3),
    .hist_guess(hist_guess3),
    .pc_check(pc_check3), .is_br_check(is_br_check3),
    .br_taken_check(br_taken_check3), .hist_check('0)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic g, input logic [31:0] pg,
                    input logic c, input logic [31:0] pcc,
                    input logic t, input logic [IW-1:0] h);
    is_br_guess = g;
    pc_guess = pg;
    is_br_check = c;
    pc_check = pcc;
    br_taken_check = t;
    hist_check = h;
    tick();
    is_br_guess = 1'b0;
    is_br_check = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t);
    op(1'b0, 32'h0, 1'b1, pc, t, '0);
  endtask

  task automatic look(input logic [31:0] pc);
    op(1'b1, pc, 1'b0, 32'h0, 1'b0, '0);
  endtask

  task automatic op3(input logic g, input logic [31:0] pg,
                     input logic c, input logic [31:0] pcc,
                     input logic t);
    is_br_guess3 = g;
    pc_guess3 = pg;
    is_br_check3 = c;
    pc_check3 = pcc;
    br_taken_check3 = t;
    tick();
    is_br_guess3 = 1'b0;
    is_br_check3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    is_br_guess = 1'b1; pc_guess = 32'h100;
    is_br_check = 1'b1; pc_check = 32'h100;
    br_taken_check = 1'b1; hist_check = '0;
    is_br_guess3 = 1'b1; pc_guess3 = 32'h100;
    is_br_check3 = 1'b1; pc_check3 = 32'h100;
    br_taken_check3 = 1'b1;
    tick();
    tick();
    check("rst_valid", pred_valid, 0);
    check("rst_taken", pred_taken, 0);
    check("rst_hist", hist_guess, 0);
    check("rst_valid3", pred_valid3, 0);
    rst = 1'b0;
    is_br_guess = 1'b0; is_br_check = 1'b0;
    is_br_guess3 = 1'b0; is_br_check3 = 1'b0;
    tick();
    check("idle_valid", pred_valid, 0);

`ifdef BHT_GSHARE_EN
    upd(32'h0, 1'b1);
    upd(32'h0, 1'b1);
    upd(32'h0, 1'b0);
    look(32'h40);
    check("gs_valid", pred_valid, 1);
    check("gs_hist", hist_guess, 6);
    check("gs_taken", pred_taken, 0);
    // update idx 0x10^6 while lookup of 0x40 uses GHR 6 -> bypass
    op(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 7'd6);
    check("gs_bypass", pred_taken, 1);
    check("gs_bypass_hist", hist_guess, 6);
    look(32'h0);
    check("gs_hist2", hist_guess, 7'h0D);
    is_br_guess = 1'b1; pc_guess = 32'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    is_br_guess = 1'b0;
    check("gs_rst_valid", pred_valid, 0);
    check("gs_rst_hist", hist_guess, 0);
    look(32'h0);
    check("gs_rst_ghr", hist_guess, 0);
    check("gs_rst_ctr", pred_taken, 0);
`else
    look(32'h100);
    check("first_valid", pred_valid, 1);
    check("first_taken", pred_taken, 0);
    tick();
    check("valid_drop", pred_valid, 0);
    upd(32'h100, 1'b1);
    upd(32'h100, 1'b1);
    look(32'h100);
    check("ctr3_taken", pred_taken, 1);
    upd(32'h100, 1'b1);
    upd(32'h100, 1'b1);
    upd(32'h100, 1'b0);
    look(32'h100);
    check("sat_hi_then_dn", pred_taken, 1);
    upd(32'h100, 1'b0);
    look(32'h100);
    check("back_to_1", pred_taken, 0);

    op(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, '0);
    check("bypass", pred_taken, 1);
    look(32'h200);
    check("bypass_stored", pred_taken, 1);
    op(1'b1, 32'h204, 1'b1, 32'h200, 1'b1, '0);
    check("distinct_look", pred_taken, 0);
    look(32'h204);
    check("distinct_kept", pred_taken, 0);

    upd(32'h000, 1'b0);
    upd(32'h000, 1'b0);
    look(32'h200);
    check("alias_200", pred_taken, 0);
    upd(32'h000, 1'b1);
    look(32'h202);
    check("alias_202", pred_taken, 1);

    op3(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    check("w3_init", pred_taken3, 0);
    for (int i = 0; i < 8; i++) op3(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 3; i++) op3(1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    op3(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    check("w3_sat_lo", pred_taken3, 0);
    op3(1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    op3(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    check("w3_ctr4", pred_taken3, 1);
    for (int i = 0; i < 4; i++) op3(1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    op3(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    check("w3_sat_hi", pred_taken3, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
